// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-channel PWM output stage.
package pwm_pkg;

  localparam int NUM_CH          = 16;
  localparam int DUTY_W          = 8;
  localparam int DEFAULT_CLK_DIV = 13;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_HIGH = 2'd1,
    CH_PWM  = 2'd2
  } ch_mode_e;

  // Prescaler width; a divide-by-1 still needs a 1-bit register to exist.
  function automatic int presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    if (!en_out)     return CH_OFF;
    else if (!en_pwm) return CH_HIGH;
    else             return CH_PWM;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the last clk of each period (wrap)
// and strobes period_start on the first clk of the next one.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] count,
  output logic       wrap,
  output logic       period_start
);

  localparam int            PW        = presc_w(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ps_q, ps_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    wrap    = tick && (cnt_q == 8'hFF);
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    ps_d    = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
    end
  end

  assign count        = cnt_q;
  assign period_start = ps_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage: per channel off / static high / shared PWM,
// with the duty value shadowed so it only changes on a period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [NUM_CH-1:0] en_out, en_pwm;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [7:0]        count;
  logic              wrap;
  logic              pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (count),
    .wrap         (wrap),
    .period_start (period_start)
  );

  // Full-scale duty is forced high so the count-255 slot does not drop out.
  always_comb begin
    duty_d    = wrap ? pwm_duty_cycle : duty_q;
    pwm_level = (duty_q == {DUTY_W{1'b1}}) || (count < duty_q);
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_mode(en_out[i], en_pwm[i]))
        CH_HIGH: out_d[i] = 1'b1;
        CH_PWM:  out_d[i] = pwm_level;
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      out_q  <= '0;
    end else begin
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Sixteen-channel PWM output stage that sits directly downstream of the SPI register peripheral. It consumes the four enable bytes and the duty-cycle byte that the SPI peripheral writes, and drives the 16 user outputs. Each output is held low, held high, or driven by a shared 8-bit PWM waveform. The waveform period is about 3 kHz at a 10 MHz clock. Duty-cycle changes take effect only at a period boundary, so no output ever sees a glitched or truncated pulse.

## Interface
Parameters:
- CLK_DIV, default 13: prescaler ratio in clk cycles per PWM count. Legal range is 1 to 256. Period = CLK_DIV × 256 clk cycles.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  asynchronous, active-low reset.
- en_reg_out_7_0  input  8  output enable for channels 7..0.
- en_reg_out_15_8  input  8  output enable for channels 15..8.
- en_reg_pwm_7_0  input  8  PWM mode select for channels 7..0.
- en_reg_pwm_15_8  input  8  PWM mode select for channels 15..8.
- pwm_duty_cycle  input  8  requested duty, in units of 1/256.
- out  output  16  channel outputs. out[7:0] drives uo_out; out[15:8] drives uio_out.
- period_start  output  1  one-cycle strobe marking the first count of each PWM period.

All inputs are synchronous to clk; they come from the SPI peripheral's clk-domain registers.

## Operation
Combined vectors:
- en_out = {en_reg_out_15_8, en_reg_out_7_0}
- en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}

Timebase:
- prescaler counts 0 to CLK_DIV-1, then wraps to 0.
- pwm_counter (8 bit) increments when prescaler = CLK_DIV-1. It wraps from 255 to 0.
- Define wrap = (prescaler = CLK_DIV-1) and (pwm_counter = 255).

Duty shadow:
- duty_shadow (8 bit) loads pwm_duty_cycle on the clk edge where wrap is true.
- At any other time, duty_shadow holds its value. Input changes mid-period are ignored until the next wrap.

Waveform:
- pwm_level = 1 when duty_shadow = 255.
- Otherwise pwm_level = 1 when pwm_counter < duty_shadow.
- duty 0 gives a constant low; duty 255 gives a constant high, with no single-count dropout.

Per channel i, the registered output is:
- en_out[i] = 0: out[i] = 0.
- en_out[i] = 1 and en_pwm[i] = 0: out[i] = 1.
- en_out[i] = 1 and en_pwm[i] = 1: out[i] = pwm_level.

Additional rules:
- Enable and mode changes are not shadowed. They act immediately, subject only to the output register.
- period_start is registered high for one cycle. It is high on the cycle after the wrap edge, i.e. while pwm_counter = 0 and prescaler = 0.

## Timing
- Reset (rst_n low, asynchronous): prescaler = 0, pwm_counter = 0, duty_shadow = 0, out = 16'h0000, period_start = 0.
  - After release, the first period runs at duty 0. The first shadow load happens at the first wrap, CLK_DIV×256 cycles after release.
- Reset asserted mid-period: all state clears immediately. The timebase restarts from 0 after release, with no partial pulse preserved.
- out latency: one clk cycle from any input or counter change to out.
- Pulse width: in a steady period, a PWM channel is high for duty_shadow×CLK_DIV consecutive cycles and low for (256−duty_shadow)×CLK_DIV cycles.
  - Exception: duty_shadow = 255 gives high for all 256×CLK_DIV cycles.
- Simultaneous events: if pwm_duty_cycle changes on the same edge as wrap, the value sampled on that edge is loaded.
- CLK_DIV = 1: the prescaler is permanently 0 and pwm_counter increments every cycle. wrap = (pwm_counter = 255).

## Structure
- Package pwm_pkg holds:
  - NUM_CH = 16
  - DUTY_W = 8
  - DEFAULT_CLK_DIV = 13
  - the prescaler width function, clog2(CLK_DIV)
- Sub-module pwm_timebase holds the prescaler, pwm_counter, and wrap/period_start generation.
  - Its ports are clk, rst_n, count[7:0], wrap, period_start.
  - The top level holds duty_shadow, the comparator, and the 16-channel output mux and register.

## Test plan
- Reset: hold rst_n low with random inputs -> out = 16'h0000 and period_start = 0 throughout. Release -> period_start first pulses at cycle 3328 (CLK_DIV = 13).
- Static high: en_out = 16'h8001, en_pwm = 0 -> out = 16'h8001 one cycle later. Clear en_out -> out = 0 one cycle later.
- PWM 50%: duty = 8'h80, en_out = en_pwm = 16'h0001. After the first shadow load, out[0] is high 1664 cycles and low 1664 cycles; period measured between period_start strobes = 3328.
- Extremes:
  - duty = 8'h00 -> out[0] constant 0 across two full periods.
  - duty = 8'hFF -> out[0] constant 1 across two full periods, with no single-count gap.
- Mid-period change: running duty 8'h40, write 8'hC0 at count 100. The current period keeps 832 high cycles; the next period has 2496 high cycles.
- Reset mid-period: assert rst_n at count 150 with duty 8'hC0 active -> out drops to 0 asynchronously. After release, the first period is all-low (duty_shadow = 0).
